// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one word per frame from the TX FIFO and shifts it out on o_tx.
// Define UART_TX_PARITY_EN to build in the optional parity bit (otherwise the parity inputs are ignored).
module uart_tx_serializer #(
    parameter int DW  = 8,
    parameter int BDW = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_enable,
    input  logic [BDW-1:0] i_baud_div,
    input  logic           i_stop2,
    input  logic           i_parity_en,
    input  logic           i_parity_odd,
    input  logic           i_fifo_empty,
    input  logic           i_fifo_valid,
    input  logic [DW-1:0]  i_fifo_data,
    input  logic           i_fifo_parity_error,
    output logic           o_fifo_rd_req,
    output logic           o_tx,
    output logic           o_busy,
    output logic           o_frame_done,
    output logic           o_perr_drop
);

    localparam int BIW = $clog2(DW);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t         state_reg, state_next;
    logic [BDW-1:0] cnt_reg, cnt_next;
    logic [BDW-1:0] div_reg, div_next;
    logic [BIW-1:0] bit_idx_reg, bit_idx_next;
    logic           stop_idx_reg, stop_idx_next;
    logic [DW-1:0]  data_reg, data_next;
    logic           stop2_reg, stop2_next;
    logic           tx_reg, tx_next;
    logic           rd_req, frame_done, perr_drop, bit_end;

`ifdef UART_TX_PARITY_EN
    logic           par_en_reg, par_en_next;
    logic           par_odd_reg, par_odd_next;
`else
    logic           unused_parity_cfg;
    assign unused_parity_cfg = i_parity_en ^ i_parity_odd;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            div_reg      <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            data_reg     <= '0;
            stop2_reg    <= 1'b0;
            tx_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_reg   <= 1'b0;
            par_odd_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            div_reg      <= div_next;
            bit_idx_reg  <= bit_idx_next;
            stop_idx_reg <= stop_idx_next;
            data_reg     <= data_next;
            stop2_reg    <= stop2_next;
            tx_reg       <= tx_next;
`ifdef UART_TX_PARITY_EN
            par_en_reg   <= par_en_next;
            par_odd_reg  <= par_odd_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        div_next      = div_reg;
        bit_idx_next  = bit_idx_reg;
        stop_idx_next = stop_idx_reg;
        data_next     = data_reg;
        stop2_next    = stop2_reg;
`ifdef UART_TX_PARITY_EN
        par_en_next   = par_en_reg;
        par_odd_next  = par_odd_reg;
`endif
        rd_req        = 1'b0;
        frame_done    = 1'b0;
        perr_drop     = 1'b0;
        tx_next       = 1'b1;
        // The counter never exceeds the latched divider, so max div needs no extra bit.
        bit_end       = (cnt_reg == div_reg);

        case (state_reg)
            S_IDLE: begin
                if (i_enable && !i_fifo_empty) begin
                    rd_req     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                data_next     = i_fifo_data;
                div_next      = i_baud_div;
                stop2_next    = i_stop2;
`ifdef UART_TX_PARITY_EN
                par_en_next   = i_parity_en;
                par_odd_next  = i_parity_odd;
`endif
                cnt_next      = '0;
                bit_idx_next  = '0;
                stop_idx_next = 1'b0;
                if (i_fifo_valid && !i_fifo_parity_error) begin
                    state_next = S_START;
                end else begin
                    perr_drop  = i_fifo_valid;
                    state_next = S_IDLE;
                end
            end
            S_START: begin
                cnt_next = bit_end ? '0 : cnt_reg + BDW'(1);
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                cnt_next = bit_end ? '0 : cnt_reg + BDW'(1);
                if (bit_end) begin
                    if (bit_idx_reg == BIW'(DW - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_next = par_en_reg ? S_PARITY : S_STOP;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + BIW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                cnt_next = bit_end ? '0 : cnt_reg + BDW'(1);
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                cnt_next = bit_end ? '0 : cnt_reg + BDW'(1);
                if (bit_end) begin
                    if (stop2_reg && !stop_idx_reg) begin
                        stop_idx_next = 1'b1;
                    end else begin
                        frame_done = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // o_tx is registered, so the line level is derived from the state being entered.
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = data_next[bit_idx_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next = (^data_next) ^ par_odd_next;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    assign o_tx          = tx_reg;
    assign o_busy        = (state_reg != S_IDLE);
    assign o_fifo_rd_req = rd_req & ~i_rst;
    assign o_frame_done  = frame_done & ~i_rst;
    assign o_perr_drop   = perr_drop & ~i_rst;

endmodule
